// File: rtl/ft245_sync_device.sv
// Device (FTDI-chip side) end of an FT245 synchronous FIFO link, bridged to AXI-Stream on both paths.
// Build option: define FT245_DEVICE_LOOPBACK_EN to loop accepted master writes back into the read path.
module ft245_sync_device #(
  parameter int bus_width = 1,
  parameter int rd_depth  = 16,
  parameter int wr_depth  = 16
) (
  input  logic                   ft245_dclk,
  input  logic                   rstn,
  inout  wire  [bus_width*8-1:0] ft245_data,
  inout  wire  [bus_width-1:0]   ft245_ben,
  input  logic                   ft245_rdn,
  input  logic                   ft245_wrn,
  input  logic                   ft245_oen,
  output logic                   ft245_rxfn,
  output logic                   ft245_txen,
  input  logic                   ft245_rstn,
  input  logic                   ft245_siwun,
  input  logic                   ft245_wakeupn,
  input  logic [bus_width*8-1:0] s_axis_tdata,
  input  logic [bus_width-1:0]   s_axis_tkeep,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [bus_width*8-1:0] m_axis_tdata,
  output logic [bus_width-1:0]   m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   overflow,
  output logic                   proto_err
);

  localparam int DW = bus_width * 8;
  localparam int EW = DW + bus_width;
  localparam int RA = $clog2(rd_depth);
  localparam int WA = $clog2(wr_depth);
  localparam logic [RA:0] RD_FULL = rd_depth[RA:0];
  localparam logic [WA:0] WR_FULL = wr_depth[WA:0];

  logic          w_rst;
  logic          w_mst_wr;
  logic          w_bad_wr;
  logic          w_bus_drv;
  logic          w_unused;

  logic [EW-1:0] r_rd_mem [rd_depth];
  logic [RA-1:0] r_rd_wptr;
  logic [RA-1:0] r_rd_rptr;
  logic [RA:0]   r_rd_count;
  logic [RA:0]   w_rd_count_nxt;
  logic          w_rd_push;
  logic          w_rd_pop;
  logic [EW-1:0] w_rd_push_word;
  logic [EW-1:0] w_rd_head;

  logic [EW-1:0] r_wr_mem [wr_depth];
  logic [WA-1:0] r_wr_wptr;
  logic [WA-1:0] r_wr_rptr;
  logic [WA:0]   r_wr_count;
  logic [WA:0]   w_wr_count_nxt;
  logic          w_wr_push;
  logic          w_wr_pop;
  logic [EW-1:0] w_wr_head;

  logic          w_m_valid;
  logic          w_drop;
  logic          w_txen_nxt;
  logic          r_rxfn;
  logic          r_txen;
  logic          r_drv;
  logic          r_overflow;
  logic          r_proto_err;

  // Either reset source clears the whole bridge on the next edge.
  assign w_rst    = ~rstn | ~ft245_rstn;
  assign w_mst_wr = ~ft245_wrn & ft245_oen;
  assign w_bad_wr = ~ft245_wrn & ~ft245_oen;

  assign w_rd_pop  = ~ft245_rdn & ~ft245_oen & ~r_rxfn & (r_rd_count != '0);
  assign w_wr_pop  = w_m_valid & m_axis_tready;
  assign w_rd_head = r_rd_mem[r_rd_rptr];
  assign w_wr_head = r_wr_mem[r_wr_rptr];

  assign w_rd_count_nxt = r_rd_count + {{RA{1'b0}}, w_rd_push} - {{RA{1'b0}}, w_rd_pop};
  assign w_wr_count_nxt = r_wr_count + {{WA{1'b0}}, w_wr_push} - {{WA{1'b0}}, w_wr_pop};

`ifdef FT245_DEVICE_LOOPBACK_EN
  localparam int          RD_SKID_I = rd_depth - 2;
  localparam logic [RA:0] RD_SKID   = RD_SKID_I[RA:0];
  logic w_rd_room;

  assign w_rd_room      = (r_rd_count != RD_FULL) | w_rd_pop;
  assign s_axis_tready  = 1'b0;
  assign w_rd_push      = w_mst_wr & w_rd_room;
  assign w_rd_push_word = {ft245_ben, ft245_data};
  assign w_wr_push      = 1'b0;
  assign w_drop         = w_mst_wr & ~w_rd_room;
  assign w_m_valid      = 1'b0;
  assign w_txen_nxt     = (w_rd_count_nxt >= RD_SKID);
  assign w_unused       = ^{ft245_siwun, ft245_wakeupn, s_axis_tdata, s_axis_tkeep, s_axis_tvalid};
`else
  localparam int          WR_SKID_I = wr_depth - 2;
  localparam logic [WA:0] WR_SKID   = WR_SKID_I[WA:0];
  logic w_wr_room;

  // A pop in the same cycle frees the slot, so a full write FIFO still takes the word.
  assign w_wr_room      = (r_wr_count != WR_FULL) | w_wr_pop;
  assign s_axis_tready  = ~w_rst & (r_rd_count != RD_FULL);
  assign w_rd_push      = s_axis_tvalid & s_axis_tready;
  assign w_rd_push_word = {s_axis_tkeep, s_axis_tdata};
  assign w_wr_push      = w_mst_wr & w_wr_room;
  assign w_drop         = w_mst_wr & ~w_wr_room;
  assign w_m_valid      = (r_wr_count != '0);
  assign w_txen_nxt     = (w_wr_count_nxt >= WR_SKID);
  assign w_unused       = ^{ft245_siwun, ft245_wakeupn};
`endif

  always_ff @(posedge ft245_dclk) begin
    if (w_rst) begin
      r_rd_wptr   <= '0;
      r_rd_rptr   <= '0;
      r_rd_count  <= '0;
      r_wr_wptr   <= '0;
      r_wr_rptr   <= '0;
      r_wr_count  <= '0;
      r_rxfn      <= 1'b1;
      r_txen      <= 1'b1;
      r_drv       <= 1'b0;
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_rd_push) r_rd_wptr <= r_rd_wptr + {{(RA-1){1'b0}}, 1'b1};
      if (w_rd_pop)  r_rd_rptr <= r_rd_rptr + {{(RA-1){1'b0}}, 1'b1};
      if (w_wr_push) r_wr_wptr <= r_wr_wptr + {{(WA-1){1'b0}}, 1'b1};
      if (w_wr_pop)  r_wr_rptr <= r_wr_rptr + {{(WA-1){1'b0}}, 1'b1};
      r_rd_count <= w_rd_count_nxt;
      r_wr_count <= w_wr_count_nxt;
      // Flags look at post-update occupancy so the last pop raises rxfn on the same edge.
      r_rxfn     <= (w_rd_count_nxt == '0);
      r_txen     <= w_txen_nxt;
      r_drv      <= ~ft245_oen;
      if (w_drop)   r_overflow  <= 1'b1;
      if (w_bad_wr) r_proto_err <= 1'b1;
    end
  end

  // NOTE: storage arrays have no reset; the counts alone decide which words are valid.
  always_ff @(posedge ft245_dclk) begin
    if (w_rd_push) r_rd_mem[r_rd_wptr] <= w_rd_push_word;
    if (w_wr_push) r_wr_mem[r_wr_wptr] <= {ft245_ben, ft245_data};
  end

  assign w_bus_drv  = r_drv & ~ft245_oen;
  assign ft245_data = w_bus_drv ? w_rd_head[DW-1:0]  : {DW{1'bz}};
  assign ft245_ben  = w_bus_drv ? w_rd_head[EW-1:DW] : {bus_width{1'bz}};

  assign ft245_rxfn    = r_rxfn;
  assign ft245_txen    = r_txen;
  assign m_axis_tvalid = w_m_valid;
  assign m_axis_tdata  = w_m_valid ? w_wr_head[DW-1:0]  : '0;
  assign m_axis_tkeep  = w_m_valid ? w_wr_head[EW-1:DW] : '0;
  assign overflow      = r_overflow;
  assign proto_err     = r_proto_err;

endmodule

// File: tb/tb_ft245_sync_device.sv
// Self-checking bench for ft245_sync_device: directed vector table, hand sequences and a
// randomized run scored against a queue-based model of the device's externally visible behaviour.
module tb_ft245_sync_device;

  localparam int RD_DEPTH = 16;
  localparam int WR_DEPTH = 16;
`ifdef FT245_DEVICE_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, ft245_rstn, rdn, wrn, oen, siwun, wakeupn;
  logic [7:0] tb_data;
  logic       tb_ben;
  wire  [7:0] ft245_data;
  wire  [0:0] ft245_ben;
  logic       rxfn, txen;
  logic [7:0] s_tdata;
  logic [0:0] s_tkeep;
  logic       s_tvalid, s_tready;
  logic [7:0] m_tdata;
  logic [0:0] m_tkeep;
  logic       m_tvalid, m_tready;
  logic       overflow, proto_err;

  // The master owns the bus whenever it holds oen high.
  assign ft245_data = oen ? tb_data : 8'bz;
  assign ft245_ben  = oen ? tb_ben  : 1'bz;

  ft245_sync_device #(.bus_width(1), .rd_depth(RD_DEPTH), .wr_depth(WR_DEPTH)) dut (
    .ft245_dclk(clk), .rstn(rstn), .ft245_data(ft245_data), .ft245_ben(ft245_ben),
    .ft245_rdn(rdn), .ft245_wrn(wrn), .ft245_oen(oen), .ft245_rxfn(rxfn), .ft245_txen(txen),
    .ft245_rstn(ft245_rstn), .ft245_siwun(siwun), .ft245_wakeupn(wakeupn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .overflow(overflow), .proto_err(proto_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: two word queues ({keep, data}) and the registered status flags.
  logic [8:0] rdq[$];
  logic [8:0] wrq[$];
  bit rxfn_m, txen_m, drv_m, ovf_m, perr_m;

  task automatic model_reset();
    rdq.delete();
    wrq.delete();
    rxfn_m = 1; txen_m = 1; drv_m = 0; ovf_m = 0; perr_m = 0;
  endtask

  task automatic check_model();
    bit rst_now;
    rst_now = !rstn || !ft245_rstn;
    check("rxfn", rxfn, rxfn_m);
    check("txen", txen, txen_m);
    check("overflow", overflow, ovf_m);
    check("proto_err", proto_err, perr_m);
    check("s_tready", s_tready, !rst_now && !LB && rdq.size() != RD_DEPTH);
    check("m_tvalid", m_tvalid, !LB && wrq.size() != 0);
    if (!LB && wrq.size() != 0) begin
      check("m_tdata", m_tdata, wrq[0][7:0]);
      check("m_tkeep", m_tkeep, wrq[0][8]);
    end else begin
      check("m_tdata_idle", m_tdata, 0);
    end
    if (drv_m && !oen && rdq.size() != 0) begin
      check("bus_data", ft245_data, rdq[0][7:0]);
      check("bus_ben", ft245_ben, rdq[0][8]);
    end else if (oen) begin
      check("bus_master_owned", ft245_data, tb_data);
    end
  endtask

  task automatic model_edge();
    int  rsz, wsz;
    bit  rpop, mpop, mw;
    if (!rstn || !ft245_rstn) begin
      model_reset();
      return;
    end
    rsz  = rdq.size();
    wsz  = wrq.size();
    rpop = !rdn && !oen && !rxfn_m && rsz != 0;
    mpop = !LB && wsz != 0 && m_tready;
    mw   = !wrn && oen;
    if (!wrn && !oen) perr_m = 1;
    if (rpop) void'(rdq.pop_front());
    if (mpop) void'(wrq.pop_front());
    if (!LB && s_tvalid && rsz != RD_DEPTH) rdq.push_back({s_tkeep, s_tdata});
    if (mw) begin
      if (LB) begin
        if (rsz < RD_DEPTH || rpop) rdq.push_back({tb_ben, tb_data});
        else ovf_m = 1;
      end else begin
        if (wsz < WR_DEPTH || mpop) wrq.push_back({tb_ben, tb_data});
        else ovf_m = 1;
      end
    end
    rxfn_m = (rdq.size() == 0);
    txen_m = (LB ? rdq.size() : wrq.size()) >= (LB ? RD_DEPTH : WR_DEPTH) - 2;
    drv_m  = !oen;
  endtask

  // Inputs are changed 1 time unit after a rising edge; outputs are sampled on the falling edge.
  task automatic begin_cycle();
    @(negedge clk);
    check_model();
  endtask

  task automatic end_cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    begin_cycle();
    end_cycle();
  endtask

  typedef struct {
    logic       rstn, oen, rdn, sv;
    logic [7:0] sd;
    logic       e_rxfn, e_txen, e_tready, e_chk;
    logic [7:0] e_bus;
  } vec_t;

  function automatic vec_t mk(logic r, logic o, logic rd, logic v, logic [7:0] d,
                              logic ex, logic et, logic er, logic ec, logic [7:0] eb);
    vec_t t;
    t.rstn = r; t.oen = o; t.rdn = rd; t.sv = v; t.sd = d;
    t.e_rxfn = ex; t.e_txen = et; t.e_tready = er; t.e_chk = ec; t.e_bus = eb;
    return t;
  endfunction

  int p_oen[4] = '{30, 20, 50, 40};
  int p_rd[4]  = '{10, 30, 70, 50};
  int p_wr[4]  = '{80, 10, 60, 50};
  int p_s[4]   = '{20, 90, 70, 50};
  int p_rdy[4] = '{10, 60, 50, 50};

  initial begin
    vec_t tbl[11];
    rstn = 0; ft245_rstn = 1; rdn = 1; wrn = 1; oen = 1; siwun = 1; wakeupn = 1;
    tb_data = 8'h3C; tb_ben = 0; s_tdata = 0; s_tkeep = 1; s_tvalid = 0; m_tready = 0;
    model_reset();
    @(posedge clk);
    #1;

`ifndef FT245_DEVICE_LOOPBACK_EN
    // Reset hold, then a three-word read burst.
    tbl[0]  = mk(0, 1, 1, 0, 8'h00, 1, 1, 0, 1, 8'h3C);
    tbl[1]  = mk(0, 1, 1, 0, 8'h00, 1, 1, 0, 1, 8'h3C);
    tbl[2]  = mk(0, 1, 1, 1, 8'h99, 1, 1, 0, 1, 8'h3C);
    tbl[3]  = mk(1, 1, 1, 1, 8'h11, 1, 1, 1, 1, 8'h3C);
    tbl[4]  = mk(1, 1, 1, 1, 8'h22, 0, 0, 1, 1, 8'h3C);
    tbl[5]  = mk(1, 0, 1, 1, 8'h33, 0, 0, 1, 0, 8'h00);
    tbl[6]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 1, 1, 8'h11);
    tbl[7]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 1, 1, 8'h22);
    tbl[8]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 1, 1, 8'h33);
    tbl[9]  = mk(1, 0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00);
    tbl[10] = mk(1, 1, 1, 0, 8'h00, 1, 0, 1, 1, 8'h3C);
    for (int i = 0; i < 11; i++) begin
      rstn = tbl[i].rstn; oen = tbl[i].oen; rdn = tbl[i].rdn;
      s_tvalid = tbl[i].sv; s_tdata = tbl[i].sd;
      begin_cycle();
      check($sformatf("vec%0d_rxfn", i), rxfn, tbl[i].e_rxfn);
      check($sformatf("vec%0d_txen", i), txen, tbl[i].e_txen);
      check($sformatf("vec%0d_tready", i), s_tready, tbl[i].e_tready);
      check($sformatf("vec%0d_tvalid", i), m_tvalid, 1'b0);
      if (tbl[i].e_chk) begin
        check($sformatf("vec%0d_bus", i), ft245_data, tbl[i].e_bus);
        check($sformatf("vec%0d_ben", i), ft245_ben, tbl[i].oen ? 1'b0 : 1'b1);
      end
      end_cycle();
    end
    s_tvalid = 0;

    // Write burst against a stalled sink: skid flag, fill, overflow, ordered drain.
    m_tready = 0;
    for (int i = 0; i < 17; i++) begin
      wrn = 0; tb_ben = 1; tb_data = 8'(8'hA0 + i);
      begin_cycle();
      check($sformatf("wb%0d_txen", i), txen, i >= 14);
      check($sformatf("wb%0d_tvalid", i), m_tvalid, i != 0);
      check($sformatf("wb%0d_ovf", i), overflow, 1'b0);
      if (i > 0) check($sformatf("wb%0d_head", i), m_tdata, 8'hA0);
      end_cycle();
    end
    wrn = 1; m_tready = 1;
    for (int k = 0; k < 16; k++) begin
      begin_cycle();
      check($sformatf("drain%0d_ovf", k), overflow, 1'b1);
      check($sformatf("drain%0d_tvalid", k), m_tvalid, 1'b1);
      check($sformatf("drain%0d_tdata", k), m_tdata, 8'(8'hA0 + k));
      end_cycle();
    end
    begin_cycle();
    check("drain_empty_tvalid", m_tvalid, 1'b0);
    check("drain_empty_tdata", m_tdata, 8'h00);
    end_cycle();
    m_tready = 0;

    // Protocol error: write strobe while the device owns the bus.
    oen = 0;
    cycle();
    wrn = 0;
    cycle();
    wrn = 1;
    for (int k = 0; k < 3; k++) begin
      begin_cycle();
      check($sformatf("perr%0d_flag", k), proto_err, 1'b1);
      check($sformatf("perr%0d_tvalid", k), m_tvalid, 1'b0);
      end_cycle();
    end
    oen = 1;
    cycle();

    // Master reset with five words buffered across both paths.
    s_tvalid = 1; s_tdata = 8'h51; wrn = 0; tb_data = 8'h61;
    cycle();
    s_tdata = 8'h52; tb_data = 8'h62;
    cycle();
    s_tdata = 8'h53; wrn = 1;
    cycle();
    s_tvalid = 0;
    begin_cycle();
    check("mrst_pre_rxfn", rxfn, 1'b0);
    check("mrst_pre_tvalid", m_tvalid, 1'b1);
    check("mrst_pre_tdata", m_tdata, 8'h61);
    end_cycle();
    ft245_rstn = 0;
    begin_cycle();
    check("mrst_tready", s_tready, 1'b0);
    end_cycle();
    ft245_rstn = 1;
    begin_cycle();
    check("mrst_rxfn", rxfn, 1'b1);
    check("mrst_tvalid", m_tvalid, 1'b0);
    check("mrst_txen", txen, 1'b1);
    check("mrst_ovf", overflow, 1'b0);
    check("mrst_perr", proto_err, 1'b0);
    check("mrst_tready_after", s_tready, 1'b1);
    end_cycle();
    begin_cycle();
    check("mrst_txen_low", txen, 1'b0);
    end_cycle();
`else
    for (int i = 0; i < 3; i++) cycle();
    rstn = 1;
    wrn = 0; tb_ben = 1; tb_data = 8'h5A;
    cycle();
    tb_data = 8'hC3;
    cycle();
    wrn = 1; oen = 0;
    cycle();
    rdn = 0;
    begin_cycle();
    check("lb_rd0", ft245_data, 8'h5A);
    check("lb_tvalid0", m_tvalid, 1'b0);
    end_cycle();
    begin_cycle();
    check("lb_rd1", ft245_data, 8'hC3);
    check("lb_tready", s_tready, 1'b0);
    end_cycle();
    rdn = 1; oen = 1;
    begin_cycle();
    check("lb_rxfn_empty", rxfn, 1'b1);
    end_cycle();
`endif

    // Randomized traffic in four differently-biased segments, each opened by a master reset.
    for (int seg = 0; seg < 4; seg++) begin
      rstn = 1; ft245_rstn = 0; oen = 1; wrn = 1; rdn = 1; s_tvalid = 0;
      cycle();
      ft245_rstn = 1;
      for (int c = 0; c < 400; c++) begin
        oen      = ($urandom_range(0, 99) >= p_oen[seg]);
        if (oen) wrn = ($urandom_range(0, 99) >= p_wr[seg]);
        else     wrn = ($urandom_range(0, 99) >= 2);
        rdn      = ($urandom_range(0, 99) >= p_rd[seg]);
        s_tvalid = ($urandom_range(0, 99) < p_s[seg]);
        m_tready = ($urandom_range(0, 99) < p_rdy[seg]);
        s_tdata  = 8'($urandom);
        s_tkeep  = 1'($urandom);
        tb_data  = 8'($urandom);
        tb_ben   = 1'($urandom);
        rstn     = (seg != 3) || ($urandom_range(0, 99) != 0);
        cycle();
      end
    end
    rstn = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
